// File: rtl/p2s_sched_pkg.sv
// Shared state type, defaults and round-robin helper for the p2s_sched shifter scheduler.
package p2s_sched_pkg;

    localparam int WORD_W_DEF      = 40;
    localparam int TIMEOUT_CYC_DEF = 1024;
    localparam int CNT_W_DEF       = $clog2(WORD_W_DEF + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ARMED,
        SHIFT
    } state_e;

    // With both slots full the channel not served last wins; otherwise the full one.
    function automatic logic pick_ch(input logic full0, input logic full1, input logic last_served);
        if (full0 && full1) return ~last_served;
        return full1;
    endfunction

endpackage

// File: rtl/p2s_sched_if.sv
// Channel, frame and shifter-side signals of p2s_sched, grouped for the module port.
interface p2s_sched_if
    import p2s_sched_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
);
    logic              Frame;
    logic              ch0_stb;
    logic              ch1_stb;
    logic [WORD_W-1:0] ch0_data;
    logic [WORD_W-1:0] ch1_data;
    logic              ovr_clr;
    logic [WORD_W-1:0] Shifted;
    logic              p2s_enable;
    logic              busy;
    logic              active_ch;
    logic [1:0]        overrun;
    logic              timeout;

    modport master (
        output Frame, ch0_stb, ch1_stb, ch0_data, ch1_data, ovr_clr,
        input  Shifted, p2s_enable, busy, active_ch, overrun, timeout
    );

    modport slave (
        input  Frame, ch0_stb, ch1_stb, ch0_data, ch1_data, ovr_clr,
        output Shifted, p2s_enable, busy, active_ch, overrun, timeout
    );
endinterface

// File: rtl/p2s_slot.sv
// One-entry word buffer for a scheduler channel, with sticky overrun flag.
module p2s_slot
    import p2s_sched_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              Sclk,
    input  logic              Clear_n,
    input  logic              stb_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              free_i,
    input  logic              ovr_clr_i,
    output logic              full_o,
    output logic [WORD_W-1:0] data_o,
    output logic              overrun_o
);
    logic              full_q, full_d;
    logic              overrun_q, overrun_d;
    logic [WORD_W-1:0] data_q;
    logic              capture, drop;

    // A slot being emptied by the scheduler this cycle still takes the strobe.
    assign capture = stb_i && (!full_q || free_i);
    assign drop    = stb_i && full_q && !free_i;

    // NOTE: every next-state value is defaulted first so no path can infer a latch.
    always_comb begin
        full_d    = full_q;
        overrun_d = overrun_q;
        if (free_i)    full_d    = 1'b0;
        if (capture)   full_d    = 1'b1;
        if (ovr_clr_i) overrun_d = 1'b0;
        if (drop)      overrun_d = 1'b1;
    end

    // NOTE: clocked state uses non-blocking assignment; combinational blocks use blocking.
    always_ff @(posedge Sclk or negedge Clear_n) begin
        if (!Clear_n) begin
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            full_q    <= full_d;
            overrun_q <= overrun_d;
        end
    end

    // NOTE: the word register carries no reset; full_q qualifies every read of it.
    always_ff @(posedge Sclk) begin
        if (capture) data_q <= data_i;
    end

    assign full_o    = full_q;
    assign data_o    = data_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/p2s_sched.sv
// Two-channel round-robin scheduler feeding the shared parallel-to-serial shifter.
// Optional ARMED-state abort enabled by defining P2S_SCHED_TIMEOUT_EN.
module p2s_sched
    import p2s_sched_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
`ifdef P2S_SCHED_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
    input  logic       Sclk,
    input  logic       Clear_n,
    p2s_sched_if.slave bus
);
    localparam int CNT_W = $clog2(WORD_W + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] shifted_q, shifted_d;
    logic              active_ch_q, active_ch_d;
    logic              last_served_q, last_served_d;
    logic              start_load, grant, expire;
    logic              full0, full1, free0, free1, ovr0, ovr1;
    logic [WORD_W-1:0] data0, data1;

    assign free0 = (state_q == LOAD) && !active_ch_q;
    assign free1 = (state_q == LOAD) &&  active_ch_q;

    p2s_slot #(.WORD_W(WORD_W)) u_slot0 (
        .Sclk      (Sclk),
        .Clear_n   (Clear_n),
        .stb_i     (bus.ch0_stb),
        .data_i    (bus.ch0_data),
        .free_i    (free0),
        .ovr_clr_i (bus.ovr_clr),
        .full_o    (full0),
        .data_o    (data0),
        .overrun_o (ovr0)
    );

    p2s_slot #(.WORD_W(WORD_W)) u_slot1 (
        .Sclk      (Sclk),
        .Clear_n   (Clear_n),
        .stb_i     (bus.ch1_stb),
        .data_i    (bus.ch1_data),
        .free_i    (free1),
        .ovr_clr_i (bus.ovr_clr),
        .full_o    (full1),
        .data_o    (data1),
        .overrun_o (ovr1)
    );

    assign grant = pick_ch(full0, full1, last_served_q);

`ifdef P2S_SCHED_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;

    assign expire = (state_q == ARMED) && !bus.Frame
                    && (wait_q == WAIT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        wait_d    = '0;
        timeout_d = timeout_q;
        if ((state_q == ARMED) && !bus.Frame) wait_d = wait_q + WAIT_W'(1);
        if (bus.ovr_clr) timeout_d = 1'b0;
        if (expire)      timeout_d = 1'b1;
    end

    always_ff @(posedge Sclk or negedge Clear_n) begin
        if (!Clear_n) begin
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign expire      = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shifted_d     = shifted_q;
        active_ch_d   = active_ch_q;
        last_served_d = last_served_q;
        start_load    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (full0 || full1) start_load = 1'b1;
            end
            LOAD: begin
                // Frame is deliberately not looked at here.
                state_d       = ARMED;
                last_served_d = active_ch_q;
            end
            ARMED: begin
                if (bus.Frame) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end else if (expire) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                // One cycle beyond the word length covers the shifter's negedge sampling.
                if (cnt_q == CNT_W'(WORD_W)) begin
                    if (full0 || full1) start_load = 1'b1;
                    else                state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_load) begin
            state_d     = LOAD;
            active_ch_d = grant;
            shifted_d   = grant ? data1 : data0;
        end
    end

    always_ff @(posedge Sclk or negedge Clear_n) begin
        if (!Clear_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            shifted_q     <= '0;
            active_ch_q   <= 1'b0;
            last_served_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shifted_q     <= shifted_d;
            active_ch_q   <= active_ch_d;
            last_served_q <= last_served_d;
        end
    end

    assign bus.Shifted    = shifted_q;
    assign bus.p2s_enable = (state_q == LOAD);
    assign bus.busy       = (state_q != IDLE);
    assign bus.active_ch  = active_ch_q;
    assign bus.overrun    = {ovr1, ovr0};

endmodule

// File: tb/tb_p2s_sched.sv
// Bench for p2s_sched: job-level reference model compared every cycle, plus directed literal checks.
module tb_p2s_sched;
    import p2s_sched_pkg::*;

    localparam int W      = WORD_W_DEF;
    localparam int TO_CYC = 16;

    logic Sclk    = 1'b0;
    logic Clear_n = 1'b1;

    p2s_sched_if #(.WORD_W(W)) bus ();

    p2s_sched #(
        .WORD_W(W)
`ifdef P2S_SCHED_TIMEOUT_EN
        , .TIMEOUT_CYC(TO_CYC)
`endif
    ) dut (
        .Sclk    (Sclk),
        .Clear_n (Clear_n),
        .bus     (bus)
    );

    always #5 Sclk = ~Sclk;

    int n_cmp  = 0;
    int n_fail = 0;
    int en_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a job is load (1 cycle), wait for Frame, then W+1 shift cycles.
    bit           m_full [2];
    logic [W-1:0] m_data [2];
    bit           m_last    = 1'b1;
    bit           m_load    = 1'b0;
    bit           m_wait    = 1'b0;
    int           m_left    = 0;
    int           m_wcnt    = 0;
    logic [W-1:0] m_shifted = '0;
    bit           m_ch      = 1'b0;
    logic [1:0]   m_ovr     = 2'b00;
    bit           m_to      = 1'b0;

    task automatic model_reset();
        m_full[0] = 1'b0; m_full[1] = 1'b0;
        m_last = 1'b1; m_load = 1'b0; m_wait = 1'b0; m_left = 0; m_wcnt = 0;
        m_shifted = '0; m_ch = 1'b0; m_ovr = 2'b00; m_to = 1'b0;
    endtask

    task automatic model_step();
        bit           old_full [2];
        logic [W-1:0] old_data [2];
        bit           stb [2];
        logic [W-1:0] din [2];
        bit           was_idle, job_done, freeing, free_ch, to_fire, fr, drop;
        stb[0] = bus.ch0_stb;  din[0] = bus.ch0_data;
        stb[1] = bus.ch1_stb;  din[1] = bus.ch1_data;
        old_full = m_full;
        old_data = m_data;
        was_idle = !(m_load || m_wait || (m_left > 0));
        job_done = 1'b0;
        to_fire  = 1'b0;
        freeing  = m_load;
        free_ch  = m_ch;
        if (m_load) begin
            m_load = 1'b0; m_wait = 1'b1; m_wcnt = 0; m_last = m_ch;
        end else if (m_wait) begin
            if (bus.Frame) begin
                m_wait = 1'b0; m_left = W + 1;
            end
`ifdef P2S_SCHED_TIMEOUT_EN
            else begin
                m_wcnt++;
                if (m_wcnt == TO_CYC) begin m_wait = 1'b0; to_fire = 1'b1; end
            end
`endif
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) job_done = 1'b1;
        end
        if ((was_idle || job_done) && (old_full[0] || old_full[1])) begin
            if (old_full[0] && old_full[1]) m_ch = !m_last;
            else                            m_ch = old_full[1];
            m_shifted = old_data[m_ch];
            m_load    = 1'b1;
        end
        for (int c = 0; c < 2; c++) begin
            fr   = freeing && (int'(free_ch) == c);
            drop = 1'b0;
            if (fr) m_full[c] = 1'b0;
            if (stb[c]) begin
                if (!old_full[c] || fr) begin m_full[c] = 1'b1; m_data[c] = din[c]; end
                else drop = 1'b1;
            end
            if (drop)             m_ovr[c] = 1'b1;
            else if (bus.ovr_clr) m_ovr[c] = 1'b0;
        end
        if (to_fire)          m_to = 1'b1;
        else if (bus.ovr_clr) m_to = 1'b0;
    endtask

    always @(posedge Sclk or negedge Clear_n) begin
        if (!Clear_n) model_reset();
        else          model_step();
    end

    always @(negedge Sclk) begin
        check("cmp_shifted", 64'(bus.Shifted),    64'(m_shifted));
        check("cmp_enable",  64'(bus.p2s_enable), 64'(m_load));
        check("cmp_busy",    64'(bus.busy),       64'(m_load || m_wait || (m_left > 0)));
        check("cmp_active",  64'(bus.active_ch),  64'(m_ch));
        check("cmp_overrun", 64'(bus.overrun),    64'(m_ovr));
        check("cmp_timeout", 64'(bus.timeout),    64'(m_to));
        if (bus.p2s_enable) en_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge Sclk);
        #2;
    endtask

    task automatic strobe(input bit s0, input logic [W-1:0] d0,
                          input bit s1, input logic [W-1:0] d1, input bit clr);
        bus.ch0_stb = s0; bus.ch0_data = d0;
        bus.ch1_stb = s1; bus.ch1_data = d1;
        bus.ovr_clr = clr;
        cyc(1);
        bus.ch0_stb = 1'b0; bus.ch1_stb = 1'b0; bus.ovr_clr = 1'b0;
    endtask

    task automatic frame_pulse();
        bus.Frame = 1'b1;
        cyc(1);
        bus.Frame = 1'b0;
    endtask

    // Returns at the negedge inside the LOAD cycle.
    task automatic wait_load(input string name, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge Sclk);
            if (bus.p2s_enable) seen = 1'b1;
            else                lat++;
        end
        check({name, "_load_seen"}, 64'(seen), 64'(1));
    endtask

    task automatic shift_until_load(output int shift_n, output int idle_n);
        bit seen;
        seen = 1'b0; shift_n = 0; idle_n = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge Sclk);
            if (bus.p2s_enable) seen = 1'b1;
            else begin
                shift_n++;
                if (!bus.busy) idle_n++;
            end
        end
        check("next_load_seen", 64'(seen), 64'(1));
    endtask

    task automatic count_busy(input int win, output int n);
        n = 0;
        repeat (win) begin
            @(negedge Sclk);
            if (bus.busy) n++;
        end
        cyc(1);
    endtask

    initial begin
        logic [W-1:0] wa, wb, w1, w2, w3, w4, wc, wd, we, wf;
        int lat, n, sn, idle_n, en0;
        wa = 40'hA0_0000_00A1; wb = 40'hB0_0000_00B2;
        w1 = 40'h11_1111_1111; w2 = 40'h22_2222_2222;
        w3 = 40'h33_3333_3333; w4 = 40'h44_4444_4444;
        wc = 40'hC0_FFEE_0C0C; wd = 40'hD0_1234_0D0D;
        we = 40'hE0_5678_0E0E; wf = 40'hF0_9ABC_0F0F;
        bus.Frame = 1'b0; bus.ovr_clr = 1'b0;
        bus.ch0_stb = 1'b0; bus.ch1_stb = 1'b0;
        bus.ch0_data = '0;  bus.ch1_data = '0;
        #1 Clear_n = 1'b0;
        cyc(3);
        check("rst_shifted", 64'(bus.Shifted),    64'(0));
        check("rst_enable",  64'(bus.p2s_enable), 64'(0));
        check("rst_busy",    64'(bus.busy),       64'(0));
        check("rst_active",  64'(bus.active_ch),  64'(0));
        check("rst_overrun", 64'(bus.overrun),    64'(0));
        check("rst_timeout", 64'(bus.timeout),    64'(0));
        Clear_n = 1'b1;
        cyc(1);

        // Single word on ch0.
        en0 = en_cnt;
        strobe(1'b1, 40'h12_3456_789A, 1'b0, '0, 1'b0);
        @(negedge Sclk);
        check("t1_busy_before_load", 64'(bus.busy), 64'(0));
        wait_load("t1", lat);
        check("t1_latency", 64'(lat),           64'(0));
        check("t1_shifted", 64'(bus.Shifted),   64'(40'h12_3456_789A));
        check("t1_active",  64'(bus.active_ch), 64'(0));
        cyc(1);
        frame_pulse();
        count_busy(60, n);
        check("t1_busy_cycles", 64'(n),              64'(W + 1));
        check("t1_en_pulses",   64'(en_cnt - en0),   64'(1));

        // Overrun on ch1 while its slot is full.
        strobe(1'b0, '0, 1'b1, w1, 1'b0);
        wait_load("t3a", lat);
        cyc(1);
        strobe(1'b0, '0, 1'b1, w2, 1'b0);
        strobe(1'b0, '0, 1'b1, w3, 1'b0);
        @(negedge Sclk);
        check("t3_overrun_set", 64'(bus.overrun), 64'(2'b10));
        cyc(1);
        strobe(1'b0, '0, 1'b1, w4, 1'b1);
        @(negedge Sclk);
        check("t3_set_beats_clr", 64'(bus.overrun), 64'(2'b10));
        cyc(1);
        strobe(1'b0, '0, 1'b0, '0, 1'b1);
        @(negedge Sclk);
        check("t3_overrun_clr", 64'(bus.overrun), 64'(0));
        cyc(1);
        frame_pulse();
        shift_until_load(sn, idle_n);
        check("t3_kept_word", 64'(bus.Shifted),   64'(w2));
        check("t3_active",    64'(bus.active_ch), 64'(1));
        cyc(1);
        frame_pulse();
        count_busy(60, n);
        check("t3_busy_cycles", 64'(n), 64'(W + 1));

        // Both channels at once: ch0 first, ch1 back-to-back.
        strobe(1'b1, wa, 1'b1, wb, 1'b0);
        wait_load("t2a", lat);
        check("t2a_shifted", 64'(bus.Shifted),   64'(wa));
        check("t2a_active",  64'(bus.active_ch), 64'(0));
        cyc(1);
        frame_pulse();
        shift_until_load(sn, idle_n);
        check("t2_shift_cycles", 64'(sn),            64'(W + 1));
        check("t2_no_idle",      64'(idle_n),        64'(0));
        check("t2b_shifted",     64'(bus.Shifted),   64'(wb));
        check("t2b_active",      64'(bus.active_ch), 64'(1));
        cyc(1);
        frame_pulse();
        count_busy(60, n);
        check("t2_busy_cycles", 64'(n), 64'(W + 1));

        // Frame during LOAD is ignored.
        en0 = en_cnt;
        strobe(1'b1, wc, 1'b0, '0, 1'b0);
        cyc(1);
        bus.Frame = 1'b1;
        @(negedge Sclk);
        check("t4_in_load", 64'(bus.p2s_enable), 64'(1));
        cyc(1);
        bus.Frame = 1'b0;
        cyc(5);
        check("t4_still_armed", 64'(bus.busy), 64'(1));
        frame_pulse();
        count_busy(60, n);
        check("t4_busy_cycles", 64'(n),            64'(W + 1));
        check("t4_en_pulses",   64'(en_cnt - en0), 64'(1));

        // Reset mid-SHIFT with a word pending.
        strobe(1'b0, '0, 1'b1, wd, 1'b0);
        wait_load("t5", lat);
        cyc(1);
        strobe(1'b1, we, 1'b0, '0, 1'b0);
        frame_pulse();
        cyc(10);
        check("t5_pre_active", 64'(bus.active_ch), 64'(1));
        Clear_n = 1'b0;
        #1;
        check("t5_rst_shifted", 64'(bus.Shifted),    64'(0));
        check("t5_rst_enable",  64'(bus.p2s_enable), 64'(0));
        check("t5_rst_busy",    64'(bus.busy),       64'(0));
        check("t5_rst_active",  64'(bus.active_ch),  64'(0));
        en0 = en_cnt;
        cyc(2);
        Clear_n = 1'b1;
        cyc(50);
        check("t5_no_reload", 64'(en_cnt - en0), 64'(0));
        check("t5_idle",      64'(bus.busy),     64'(0));

        // Frame withheld.
        strobe(1'b1, wf, 1'b0, '0, 1'b0);
        wait_load("t6", lat);
        cyc(1);
`ifdef P2S_SCHED_TIMEOUT_EN
        cyc(10);
        check("t6_still_armed", 64'(bus.busy),    64'(1));
        check("t6_no_timeout",  64'(bus.timeout), 64'(0));
        cyc(10);
        check("t6_aborted",     64'(bus.busy),    64'(0));
        check("t6_timeout_set", 64'(bus.timeout), 64'(1));
        strobe(1'b0, '0, 1'b0, '0, 1'b1);
        @(negedge Sclk);
        check("t6_timeout_clr", 64'(bus.timeout), 64'(0));
        cyc(1);
`else
        cyc(40);
        check("t6_still_armed", 64'(bus.busy),    64'(1));
        check("t6_timeout_off", 64'(bus.timeout), 64'(0));
        frame_pulse();
        count_busy(60, n);
        check("t6_busy_cycles", 64'(n), 64'(W + 1));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
